sabana_ram_host: RTL and testbench

SABANA_RAM_HOST -- requirements
Module: sabana_ram_host

---
 rtl/sabana_ram_host.sv | 147 ++++++++++++++
 tb/tb_sabana_ram_host.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sabana_ram_host.sv
// Host-side sequencer: loads a word RAM from a stream, lends it to a kernel, then streams it back.
// state   | meaning
// IDLE    | waiting for go; kernel held in reset
// LOAD    | accepting the load stream into mem[ptr]
// RUN     | kernel owns the RAM port until k_finish
// FETCH   | read address = ptr; word lands in the rdata register next cycle
// PRESENT | ul_data offered and held until accepted
// DONE    | one-cycle done pulse, then back to IDLE
module sabana_ram_host #(
    parameter int DW = 32,
    parameter int AW = 6
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          go,
    output logic          busy,
    output logic          done,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [DW-1:0] ld_data,
    output logic          ul_valid,
    input  logic          ul_ready,
    output logic [DW-1:0] ul_data,
    output logic          k_reset,
    output logic          k_start,
    input  logic          k_finish,
    input  logic [AW-1:0] k_addr,
    input  logic          k_we,
    input  logic [DW-1:0] k_wdata,
    output logic [DW-1:0] k_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_FETCH,
        S_PRESENT,
        S_DONE
    } state_t;

    localparam logic [AW-1:0] PTR_LAST = '1;

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          run_first_q, run_first_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic [DW-1:0] mem [2**AW];
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_wdata;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        run_first_d = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = ptr_q;
        mem_wdata   = ld_data;
        mem_raddr   = ptr_q;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d = S_LOAD;
                    ptr_d   = '0;
                end
            end
            S_LOAD: begin
                if (ld_valid) begin
                    mem_we = 1'b1;
                    ptr_d  = ptr_q + 1'b1;
                    if (ptr_q == PTR_LAST) begin
                        state_d     = S_RUN;
                        run_first_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                mem_we    = k_we;
                mem_waddr = k_addr;
                mem_wdata = k_wdata;
                mem_raddr = k_addr;
                // A finish on the start cycle is stale kernel state, not a real completion.
                if (k_finish && !run_first_q) begin
                    state_d = S_FETCH;
                    ptr_d   = '0;
                end
            end
            S_FETCH: begin
                state_d = S_PRESENT;
            end
            S_PRESENT: begin
                if (ul_ready) begin
                    if (ptr_q == PTR_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        ptr_d   = ptr_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        rdata_d = mem[mem_raddr];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            run_first_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            run_first_q <= run_first_d;
            rdata_q     <= rdata_d;
        end
    end

    // RAM contents survive reset on purpose.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign ld_ready = (state_q == S_LOAD);
    assign ul_valid = (state_q == S_PRESENT);
    assign ul_data  = rdata_q;
    assign k_rdata  = rdata_q;
    assign k_reset  = (state_q != S_RUN);
    assign k_start  = (state_q == S_RUN) && run_first_q;

endmodule

// File: tb/tb_sabana_ram_host.sv
// Bench for sabana_ram_host: bench-side add kernel, expected-word queue scoreboard, directed job sequence.
module tb_sabana_ram_host;
    localparam int DW = 32;
    localparam int AW = 6;
    localparam int N  = 64;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          go = 1'b0;
    logic          busy, done;
    logic          ld_valid = 1'b0;
    logic          ld_ready;
    logic [DW-1:0] ld_data = '0;
    logic          ul_valid;
    logic          ul_ready = 1'b0;
    logic [DW-1:0] ul_data;
    logic          k_reset, k_start;
    logic          k_finish = 1'b0;
    logic [AW-1:0] k_addr = '0;
    logic          k_we = 1'b0;
    logic [DW-1:0] k_wdata = '0;
    logic [DW-1:0] k_rdata;

    sabana_ram_host #(.DW(DW), .AW(AW)) dut (
        .clock(clock), .reset(reset), .go(go), .busy(busy), .done(done),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .ul_valid(ul_valid), .ul_ready(ul_ready), .ul_data(ul_data),
        .k_reset(k_reset), .k_start(k_start), .k_finish(k_finish),
        .k_addr(k_addr), .k_we(k_we), .k_wdata(k_wdata), .k_rdata(k_rdata)
    );

    always #5 clock = ~clock;

    int total = 0;
    int passed = 0;
    int done_cnt = 0;
    int kstart_cnt = 0;
    bit chk_on = 1'b0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] job_data[N];
    logic          held_v = 1'b0;
    logic [DW-1:0] held_d = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Scoreboard: every accepted unload word must be the next expected word; stalled words must hold.
    always @(negedge clock) begin
        #2;
        if (!reset) begin
            held_v = 1'b0;
        end else if (chk_on) begin
            if (done) done_cnt++;
            if (k_start) kstart_cnt++;
            chk("ld_ul_exclusive", 64'(ld_ready & ul_valid), 64'd0);
            if (k_start) chk("kstart_kreset", 64'(k_reset), 64'd0);
            if (done) chk("done_busy", 64'(busy), 64'd1);
            if (ul_valid && held_v) chk("ul_hold", 64'(ul_data), 64'(held_d));
            if (ul_valid && ul_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL ul_extra: got 0x%0h expected no word at %0t", ul_data, $time);
                end else begin
                    chk("ul_data", 64'(ul_data), 64'(exp_q.pop_front()));
                end
                held_v = 1'b0;
            end else if (ul_valid) begin
                held_v = 1'b1;
                held_d = ul_data;
            end else begin
                held_v = 1'b0;
            end
        end
    end

    task automatic start_job();
        go = 1'b1;
        @(negedge clock);
        go = 1'b0;
        #1;
        chk("load_busy", 64'(busy), 64'd1);
        chk("load_ld_ready", 64'(ld_ready), 64'd1);
        chk("load_k_reset", 64'(k_reset), 64'd1);
    endtask

    task automatic load_job(input bit gap, input int go_at, input bit kwe_noise);
        int cnt;
        int cyc;
        bit tog;
        cnt = 0;
        cyc = 0;
        tog = 1'b1;
        if (kwe_noise) begin
            k_we = 1'b1;
            k_addr = AW'(3);
            k_wdata = 32'hDEAD_BEEF;
        end
        while (cnt < N && cyc < 4 * N) begin
            ld_valid = gap ? tog : 1'b1;
            tog = !tog;
            ld_data = job_data[cnt];
            go = (cnt == go_at);
            #1;
            if (cnt == 1 && !ld_valid) chk("ld_ready_in_gap", 64'(ld_ready), 64'd1);
            if (ld_valid && ld_ready) cnt++;
            @(negedge clock);
            cyc++;
        end
        ld_valid = 1'b0;
        go = 1'b0;
        k_we = 1'b0;
        chk("load_count", 64'(cnt), 64'(N));
        #1;
        chk("run_k_reset", 64'(k_reset), 64'd0);
        chk("run_k_start", 64'(k_start), 64'd1);
        chk("run_ld_ready", 64'(ld_ready), 64'd0);
    endtask

    // Bench kernel: mem[a] += add for every address, one read then one write per word.
    task automatic run_kernel(input logic [DW-1:0] add, input bit go_mid, input bit early);
        logic [DW-1:0] v;
        int ks0;
        ks0 = kstart_cnt;
        if (early) begin
            k_finish = 1'b1;
            @(negedge clock);
            k_finish = 1'b0;
            #1;
            chk("early_finish_ignored", 64'(k_reset), 64'd0);
            chk("kstart_gone", 64'(k_start), 64'd0);
        end
        for (int a = 0; a < N; a++) begin
            k_addr = AW'(a);
            k_we = 1'b0;
            if (go_mid && a == 20) go = 1'b1;
            @(negedge clock);
            go = 1'b0;
            #1;
            v = k_rdata;
            k_we = 1'b1;
            k_wdata = v + add;
            @(negedge clock);
        end
        k_we = 1'b0;
        k_finish = 1'b1;
        @(negedge clock);
        k_finish = 1'b0;
        #1;
        chk("fetch_k_reset", 64'(k_reset), 64'd1);
        chk("fetch_ul_valid", 64'(ul_valid), 64'd0);
        chk("kstart_once", 64'(kstart_cnt - ks0), 64'd1);
    endtask

    task automatic unload_job(input logic [DW-1:0] add, input int stall_word,
                              input logic [DW-1:0] lit0, input logic [DW-1:0] lit_stall,
                              input logic [DW-1:0] lit_last);
        int n;
        int cyc;
        int stall;
        int last_hs;
        int d0;
        n = 0;
        cyc = 0;
        stall = 0;
        last_hs = 0;
        d0 = done_cnt;
        for (int i = 0; i < N; i++) exp_q.push_back(job_data[i] + add);
        while (n < N && cyc < 8 * N) begin
            ul_ready = !(n == stall_word && stall < 10);
            #1;
            if (ul_valid && !ul_ready) begin
                stall++;
                if (stall == 5) chk("stall_hold_lit", 64'(ul_data), 64'(lit_stall));
            end
            if (ul_valid && ul_ready) begin
                if (n == 0) chk("first_word_lit", 64'(ul_data), 64'(lit0));
                if (n == 1) chk("ul_rate", 64'(cyc - last_hs), 64'd2);
                if (n == N - 1) chk("last_word_lit", 64'(ul_data), 64'(lit_last));
                last_hs = cyc;
                n++;
            end
            @(negedge clock);
            cyc++;
        end
        ul_ready = 1'b0;
        chk("unload_count", 64'(n), 64'(N));
        if (stall_word >= 0) chk("stall_cycles", 64'(stall), 64'd10);
        #1;
        chk("done_pulse", 64'(done), 64'd1);
        chk("done_k_reset", 64'(k_reset), 64'd1);
        @(negedge clock);
        #1;
        chk("done_once", 64'(done_cnt - d0), 64'd1);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_done", 64'(done), 64'd0);
        chk("idle_k_reset", 64'(k_reset), 64'd1);
        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected job completion");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clock);
        @(negedge clock);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ld_ready", 64'(ld_ready), 64'd0);
        chk("rst_ul_valid", 64'(ul_valid), 64'd0);
        chk("rst_k_start", 64'(k_start), 64'd0);
        chk("rst_k_reset", 64'(k_reset), 64'd1);
        chk("rst_ul_data", 64'(ul_data), 64'd0);
        chk("rst_k_rdata", 64'(k_rdata), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        chk_on = 1'b1;
        @(negedge clock);

        // Job 1: data i, +5, go during LOAD and RUN, word 7 stalled 10 cycles.
        for (int i = 0; i < N; i++) job_data[i] = DW'(i);
        start_job();
        load_job(1'b0, 10, 1'b0);
        run_kernel(32'd5, 1'b1, 1'b0);
        unload_job(32'd5, 7, 32'd5, 32'd12, 32'h44);

        // Job 2 back-to-back: gapped load, k_we noise during LOAD, early k_finish ignored.
        for (int i = 0; i < N; i++) job_data[i] = DW'(1000 + 3 * i);
        start_job();
        load_job(1'b1, -1, 1'b1);
        run_kernel(32'd7, 1'b0, 1'b1);
        unload_job(32'd7, -1, 32'd1007, 32'd0, 32'd1196);

        // Job 3: abandoned by reset in RUN.
        for (int i = 0; i < N; i++) job_data[i] = DW'(i);
        start_job();
        load_job(1'b0, -1, 1'b0);
        k_addr = AW'(5);
        @(negedge clock);
        @(negedge clock);
        #1;
        chk("pre_reset_k_rdata", 64'(k_rdata), 64'd5);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_ld_ready", 64'(ld_ready), 64'd0);
        chk("arst_ul_valid", 64'(ul_valid), 64'd0);
        chk("arst_k_start", 64'(k_start), 64'd0);
        chk("arst_k_reset", 64'(k_reset), 64'd1);
        chk("arst_ul_data", 64'(ul_data), 64'd0);
        chk("arst_k_rdata", 64'(k_rdata), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        k_addr = '0;
        @(negedge clock);

        // Job 4: all-ones data plus one wraps to zero.
        for (int i = 0; i < N; i++) job_data[i] = 32'hFFFF_FFFF;
        start_job();
        load_job(1'b0, -1, 1'b0);
        run_kernel(32'd1, 1'b0, 1'b0);
        unload_job(32'd1, -1, 32'd0, 32'd0, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
